// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package seq_divider_pkg;

  localparam int DIV_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_sub_cla.sv
// Subtractor A - B built from 4-bit carry-lookahead slices; combinational, no backpressure.
// oC = 1 means no borrow (A >= B).
module adder4 (
  input  logic [3:0] iA,
  input  logic [3:0] iB,
  input  logic       iC,
  output logic [3:0] oS,
  output logic       oC
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = iA & iB;
  assign p = iA ^ iB;

  assign c[0] = iC;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign oS = p ^ c[3:0];
  assign oC = c[4];

endmodule

module sub_cla #(
  parameter int N = 20
) (
  input  logic [N-1:0] iA,
  input  logic [N-1:0] iB,
  output logic [N-1:0] oDiff,
  output logic         oC
);

  localparam int SLICES = N / 4;

  logic [N-1:0]    b_n;
  logic [SLICES:0] carry;

  // Two's-complement subtract: invert B, inject 1 at the bottom of the chain.
  assign b_n      = ~iB;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < SLICES; i++) begin : g_slice
    adder4 u_add4 (
      .iA (iA[4*i +: 4]),
      .iB (b_n[4*i +: 4]),
      .iC (carry[i]),
      .oS (oDiff[4*i +: 4]),
      .oC (carry[i+1])
    );
  end

  assign oC = carry[SLICES];

endmodule

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; result valid WIDTH+1 cycles after accept
// (1 cycle for divide-by-zero). Accepts only in IDLE; holds the result in DONE until iReady.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter  int WIDTH = DIV_DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oQuotient,
  output logic [WIDTH-1:0] oRemainder,
  output logic             oDivByZero,
  output logic             oBusy
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dz_out_q, dz_out_d;

  logic [WIDTH+3:0] sub_a;
  logic [WIDTH+3:0] sub_b;
  logic [WIDTH+3:0] sub_diff;
  logic             no_borrow;
  logic [WIDTH-1:0] shifted_rem;
  logic             sub_hi_unused;

  // Trial subtraction of {R, Q[MSB]} against the divisor, widened to whole 4-bit slices.
  assign sub_a       = {3'b000, rem_q, quo_q[WIDTH-1]};
  assign sub_b       = {4'b0000, dvs_q};
  assign shifted_rem = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign sub_hi_unused = ^sub_diff[WIDTH+3:WIDTH];

  sub_cla #(.N(WIDTH + 4)) u_sub (
    .iA    (sub_a),
    .iB    (sub_b),
    .oDiff (sub_diff),
    .oC    (no_borrow)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    dz_d      = dz_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dz_out_d  = dz_out_q;

    case (state_q)
      IDLE: begin
        if (iValid) begin
          dvs_d   = iDivisor;
          state_d = RUN;
          // Divide-by-zero preloads its fixed answer and spends zero iterations in RUN,
          // which yields the one-cycle result latency.
          if (iDivisor == '0) begin
            quo_d = '1;
            rem_d = iDividend;
            dz_d  = 1'b1;
            cnt_d = '0;
          end else begin
            quo_d = iDividend;
            rem_d = '0;
            dz_d  = 1'b0;
            cnt_d = CNT_W'(WIDTH);
          end
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d   = DONE;
          quo_out_d = quo_q;
          rem_out_d = rem_q;
          dz_out_d  = dz_q;
        end else begin
          rem_d = no_borrow ? sub_diff[WIDTH-1:0] : shifted_rem;
          quo_d = {quo_q[WIDTH-2:0], no_borrow};
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (iReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dz_q      <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dz_out_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      dz_q      <= dz_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dz_out_q  <= dz_out_d;
    end
  end

  assign oReady     = (state_q == IDLE);
  assign oValid     = (state_q == DONE);
  assign oBusy      = (state_q == RUN) || (state_q == DONE);
  assign oQuotient  = quo_out_q;
  assign oRemainder = rem_out_q;
  assign oDivByZero = dz_out_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized scoreboard bench for seq_divider against a plain a/b, a%b reference model.
module tb_seq_divider;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic         iClk;
  logic         iRst_n;
  logic         iValid;
  logic         oReady;
  logic [W-1:0] iDividend;
  logic [W-1:0] iDivisor;
  logic         oValid;
  logic         iReady;
  logic [W-1:0] oQuotient;
  logic [W-1:0] oRemainder;
  logic         oDivByZero;
  logic         oBusy;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iValid     (iValid),
    .oReady     (oReady),
    .iDividend  (iDividend),
    .iDivisor   (iDivisor),
    .oValid     (oValid),
    .iReady     (iReady),
    .oQuotient  (oQuotient),
    .oRemainder (oRemainder),
    .oDivByZero (oDivByZero),
    .oBusy      (oBusy)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q  = {W{1'b1}};
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: each DONE cycle with iReady high is exactly one consumed result.
  initial begin
    exp_t e;
    forever begin
      @(negedge iClk);
      if (iRst_n && oValid && iReady) begin
        chk("result_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("quotient", oQuotient, e.q);
          chk("remainder", oRemainder, e.r);
          chk("div_by_zero", oDivByZero, e.dz);
        end
      end
    end
  end

  // Issue one request; returns #1 after the accept edge. Caller must be away from a posedge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    int n = 0;
    while (!oReady && n < 200) begin
      @(negedge iClk);
      n++;
    end
    if (!oReady) begin
      checks++;
      failures++;
      $display("FAIL send_timeout oReady=0 after %0d cycles", n);
    end
    iValid    = 1'b1;
    iDividend = a;
    iDivisor  = b;
    if (push) sb.push_back(model(a, b));
    @(posedge iClk);
    #1;
    iValid    = 1'b0;
    iDividend = W'($urandom);
    iDivisor  = W'($urandom);
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(posedge iClk);
      #1;
      k++;
    end while (!oValid && k < 60);
  endtask

  task automatic lat_req(input logic [W-1:0] a, input logic [W-1:0] b, input int exp_lat,
                         input string name);
    int k;
    send(a, b, 1'b1);
    wait_valid(k);
    chk(name, k, exp_lat);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!oReady && n < 200) begin
      @(negedge iClk);
      n++;
    end
    chk("wait_idle", oReady, 1'b1);
  endtask

  initial begin
    logic [W-1:0] a, b;
    int           k, sel, n;

    iRst_n    = 1'b0;
    iValid    = 1'b0;
    iReady    = 1'b1;
    iDividend = '0;
    iDivisor  = '0;
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_oValid", oValid, 1'b0);
    chk("rst_oQuotient", oQuotient, 16'h0);
    chk("rst_oRemainder", oRemainder, 16'h0);
    chk("rst_oDivByZero", oDivByZero, 1'b0);
    chk("rst_oBusy", oBusy, 1'b0);
    chk("rst_oReady", oReady, 1'b1);
    @(negedge iClk);
    iRst_n = 1'b1;
    @(negedge iClk);

    lat_req(16'd100, 16'd7, 17, "latency_100_7");
    send(16'hFFFF, 16'h0001, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    send(16'd3, 16'd10, 1'b1);
    wait_idle();
    lat_req(16'd5, 16'd0, 1, "latency_div0");
    send(16'd9, 16'd3, 1'b1);
    wait_idle();

    // Backpressure: result must hold and new requests must be ignored.
    iReady = 1'b0;
    send(16'd200, 16'd9, 1'b1);
    wait_valid(k);
    chk("bp_latency", k, 17);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        iValid    = 1'b1;
        iDividend = 16'd77;
        iDivisor  = 16'd0;
      end
      if (i == 6) iValid = 1'b0;
      @(negedge iClk);
      chk("bp_oValid", oValid, 1'b1);
      chk("bp_oReady", oReady, 1'b0);
      chk("bp_quotient", oQuotient, 16'd22);
      chk("bp_remainder", oRemainder, 16'd2);
      chk("bp_div_by_zero", oDivByZero, 1'b0);
    end
    @(posedge iClk);
    #1;
    iReady = 1'b1;
    @(posedge iClk);
    #1;
    chk("bp_release_oValid", oValid, 1'b0);
    chk("bp_release_oReady", oReady, 1'b1);
    chk("bp_release_oBusy", oBusy, 1'b0);

    // Reset during iteration 8: nothing may be presented.
    send(16'd1000, 16'd3, 1'b0);
    repeat (7) @(posedge iClk);
    #1;
    iRst_n = 1'b0;
    #1;
    chk("midrst_oValid", oValid, 1'b0);
    chk("midrst_oQuotient", oQuotient, 16'h0);
    chk("midrst_oRemainder", oRemainder, 16'h0);
    chk("midrst_oDivByZero", oDivByZero, 1'b0);
    chk("midrst_oBusy", oBusy, 1'b0);
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge iClk);
      chk("midrst_no_valid", oValid, 1'b0);
    end
    lat_req(16'd1000, 16'd3, 17, "latency_1000_3");

    // Random back-to-back sweep.
    for (int i = 0; i < 2000; i++) begin
      sel = int'($urandom_range(0, 7));
      a   = W'($urandom);
      case (sel)
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = a;
        3:       b = {W{1'b1}};
        default: b = W'($urandom);
      endcase
      send(a, b, 1'b1);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge iClk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
